// File: rtl/half_splitter.sv
// half_splitter: narrowing serializer. Accepts one 2*HALF_W-bit word over a
// valid/ready handshake and emits it as two HALF_W-bit beats, low half first,
// over a second valid/ready handshake. Holds at most one word and can take a new
// word on the same edge that the final beat leaves, so a steady stream moves
// one halfword per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_32      word to split
//   in_valid   in_32 is valid this cycle
//   in_ready   word is accepted this cycle (combinational on out_ready on the final beat)
//   out_16     halfword being presented (0 when out_valid is low)
//   out_valid  out_16 is valid
//   out_ready  consumer takes out_16 this cycle
//   out_hi     out_16 is the upper half
//   out_last   out_16 is the final beat of its word
//   busy       a word is held
//
// Build option:
//   HI_ZERO_SKIP_EN  when defined, a word whose upper half is zero is emitted as a
//                    single low-half beat marked out_last; when undefined every
//                    word takes exactly two beats.
module half_splitter #(
  parameter int unsigned HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*HALF_W-1:0]   in_32,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [HALF_W-1:0]     out_16,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_hi,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi
  } state_e;

  state_e                state_q, state_d;
  logic [2*HALF_W-1:0]   word_q, word_d;
  logic [HALF_W-1:0]     out_16_q, out_16_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_hi_q, out_hi_d;
  logic                  out_last_q, out_last_d;
  logic                  skip_d;
  logic                  accept;
  logic                  depart;

  // A new word can enter whenever the block is empty, or when the beat now on
  // the output is the word's last one and is leaving this cycle. In the default
  // build out_last_q is never set in StLo, so the StLo arm reduces to 0.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      StIdle:  in_ready = 1'b1;
      StLo:    in_ready = out_last_q & out_ready;
      StHi:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign depart = out_valid_q & out_ready;

  // Next state. Acceptance wins over departure so a back-to-back word never
  // inserts a bubble.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    if (accept) begin
      word_d  = in_32;
      state_d = StLo;
    end else if (depart) begin
      state_d = out_last_q ? StIdle : StHi;
    end
  end

`ifdef HI_ZERO_SKIP_EN
  assign skip_d = (word_d[2*HALF_W-1:HALF_W] == '0);
`else
  assign skip_d = 1'b0;
`endif

  // Output decode from the next state so the presented beat is registered and
  // stays stable while the consumer stalls.
  always_comb begin
    out_valid_d = 1'b0;
    out_16_d    = '0;
    out_hi_d    = 1'b0;
    out_last_d  = 1'b0;
    case (state_d)
      StLo: begin
        out_valid_d = 1'b1;
        out_16_d    = word_d[HALF_W-1:0];
        out_last_d  = skip_d;
      end
      StHi: begin
        out_valid_d = 1'b1;
        out_16_d    = word_d[2*HALF_W-1:HALF_W];
        out_hi_d    = 1'b1;
        out_last_d  = 1'b1;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      word_q      <= '0;
      out_16_q    <= '0;
      out_valid_q <= 1'b0;
      out_hi_q    <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      out_16_q    <= out_16_d;
      out_valid_q <= out_valid_d;
      out_hi_q    <= out_hi_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_16    = out_16_q;
  assign out_valid = out_valid_q;
  assign out_hi    = out_hi_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_half_splitter.sv
// Testbench for half_splitter. The reference model is a queue of pending output
// beats: each accepted word pushes its beats, each output transfer pops one.
module tb_half_splitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_32 = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_16;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_hi;
  logic        out_last;
  logic        busy;

  int n_asserts = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] data;
    logic        hi;
    logic        last;
  } beat_t;

  beat_t q[$];

  half_splitter #(.HALF_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_32     (in_32),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_16    (out_16),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hi    (out_hi),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return (q.size() == 0) || (q.size() == 1 && out_ready);
  endfunction

  task automatic push_word(input logic [31:0] w);
    beat_t b;
`ifdef HI_ZERO_SKIP_EN
    if (w[31:16] == 16'h0) begin
      b.data = w[15:0]; b.hi = 1'b0; b.last = 1'b1;
      q.push_back(b);
      return;
    end
`endif
    b.data = w[15:0];  b.hi = 1'b0; b.last = 1'b0;
    q.push_back(b);
    b.data = w[31:16]; b.hi = 1'b1; b.last = 1'b1;
    q.push_back(b);
  endtask

  // Compare every output against the model's view of the current cycle.
  task automatic check_all(input string tag);
    if (q.size() == 0) begin
      chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd0);
      chk({tag, ".out_16"},    {16'b0, out_16},    32'd0);
      chk({tag, ".out_hi"},    {31'b0, out_hi},    32'd0);
      chk({tag, ".out_last"},  {31'b0, out_last},  32'd0);
      chk({tag, ".busy"},      {31'b0, busy},      32'd0);
    end else begin
      chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, ".out_16"},    {16'b0, out_16},    {16'b0, q[0].data});
      chk({tag, ".out_hi"},    {31'b0, out_hi},    {31'b0, q[0].hi});
      chk({tag, ".out_last"},  {31'b0, out_last},  {31'b0, q[0].last});
      chk({tag, ".busy"},      {31'b0, busy},      32'd1);
    end
    chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, model_ready()});
  endtask

  // One clock cycle: drive, check at the falling edge, advance model at the rising edge.
  task automatic cycle(input string tag, input logic iv, input logic [31:0] d,
                       input logic ordy);
    bit acc;
    bit dep;
    in_valid  = iv;
    in_32     = d;
    out_ready = ordy;
    @(negedge clk);
    check_all(tag);
    acc = iv && model_ready();
    dep = (q.size() != 0) && ordy;
    @(posedge clk);
    if (dep) void'(q.pop_front());
    if (acc) push_word(d);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Basic split with consumer always ready
    cycle("basic_in", 1'b1, 32'h1234_ABCD, 1'b1);
    cycle("basic_lo", 1'b0, 32'h0, 1'b1);
    cycle("basic_hi", 1'b0, 32'h0, 1'b1);
    cycle("basic_idle", 1'b0, 32'h0, 1'b1);

    // Back-to-back words
    cycle("b2b_w0", 1'b1, 32'h0001_0002, 1'b1);
    cycle("b2b_lo0", 1'b1, 32'h0003_0004, 1'b1);
    cycle("b2b_hi0", 1'b1, 32'h0003_0004, 1'b1);
    cycle("b2b_lo1", 1'b0, 32'h0, 1'b1);
    cycle("b2b_hi1", 1'b0, 32'h0, 1'b1);
    cycle("b2b_idle", 1'b0, 32'h0, 1'b1);

    // Stall in LO and HI with a pending input word
    cycle("stall_in", 1'b1, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 3; i++) cycle("stall_lo", 1'b1, 32'h5555_AAAA, 1'b0);
    cycle("stall_lo_go", 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("stall_hi", 1'b1, 32'h5555_AAAA, 1'b0);
    cycle("stall_hi_go", 1'b0, 32'h0, 1'b1);
    cycle("stall_idle", 1'b0, 32'h0, 1'b1);

    // Asynchronous reset while the high half is presented
    cycle("rst_in", 1'b1, 32'hCAFE_F00D, 1'b0);
    cycle("rst_lo", 1'b0, 32'h0, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    q.delete();
    check_all("rst_async");
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle("rst_after", 1'b0, 32'h0, 1'b1);

    // Zero-extended word
    cycle("zext_in", 1'b1, 32'h0000_00FF, 1'b1);
    cycle("zext_b0", 1'b0, 32'h0, 1'b1);
    cycle("zext_b1", 1'b0, 32'h0, 1'b1);
    cycle("zext_idle", 1'b0, 32'h0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(3) == 0) w[31:16] = 16'h0;
      cycle("rand", ($urandom_range(3) != 0), w, ($urandom_range(9) < 7));
    end
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 32'h0, 1'b1);
    chk("drain_empty", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/half_splitter.md
# half_splitter

Narrowing serializer for the multicycle datapath, performing the inverse of zero-extension. It accepts a 32-bit word over a valid/ready handshake and emits it as two 16-bit halfwords, low half first, over a second valid/ready handshake. It sits between 32-bit register/ALU results and 16-bit consumers such as the halfword store path and the debug port. It holds at most one word.

## Interface
- HALF_W, 16, halfword width; the input word is 2*HALF_W bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_32  input  2*HALF_W  word to split.
- in_valid  input  1  in_32 is valid this cycle.
- in_ready  output  1  block accepts in_32 this cycle.
- out_16  output  HALF_W  halfword being presented.
- out_valid  output  1  out_16 is valid.
- out_ready  input  1  consumer takes out_16 this cycle.
- out_hi  output  1  out_16 is the upper half.
- out_last  output  1  out_16 is the final beat of its word.
- busy  output  1  a word is held (state != IDLE).

## Operation
- Internal word register `word` (2*HALF_W bits), reset 0.
- Three states: IDLE, LO, HI. Reset state is IDLE.
- A transfer occurs on a rising edge where valid && ready, on either side.
- In IDLE:
  - in_ready=1, out_valid=0, out_16=0, out_hi=0, out_last=0.
  - On in_valid: word<=in_32, go to LO.
- In LO:
  - out_valid=1, out_16=word[HALF_W-1:0], out_hi=0, out_last=0, in_ready=0.
  - On out_ready: go to HI.
- In HI:
  - out_valid=1, out_16=word[2*HALF_W-1:HALF_W], out_hi=1, out_last=1, in_ready=out_ready.
  - On out_ready && in_valid: word<=in_32, go to LO (back-to-back).
  - On out_ready && !in_valid: go to IDLE.
  - On !out_ready: hold.
- While out_valid=1 and out_ready=0, out_16, out_hi and out_last stay stable.
- out_16 is 0 whenever out_valid=0.
- In_32 is never modified. Halves are bit-exact slices; no sign or zero processing.
- in_ready depends combinationally on out_ready in HI only. Every other output is a function of registered state.

## Timing
- Reset values (async assert): state=IDLE, word=0, in_ready=1, out_valid=0, out_16=0, out_hi=0, out_last=0, busy=0.
- Reset asserted mid-word discards the held word. No beat is emitted after release until a new word is accepted.
- Latency: a word accepted at edge N presents its low half in the cycle after N.
- With out_ready held at 1, the low half transfers at N+1 and the high half at N+2.
- Sustained throughput is one halfword per cycle: a new word is accepted on the same edge the high half departs.
- Simultaneous in_valid and the high-half transfer always accepts the new word. No bubble is inserted.

## Configuration
- Macro HI_ZERO_SKIP_EN.
- Defined:
  - In LO, if word[2*HALF_W-1:HALF_W]==0, then out_last=1 and in_ready=out_ready.
  - On out_ready, the block skips HI and goes to LO (if in_valid, capturing in_32) or to IDLE.
  - A zero-extended word therefore costs one beat.
- Undefined: every word is emitted as exactly two beats, including words whose upper half is zero.

## Test plan
- Reset, then in_32=32'h1234_ABCD with out_ready=1:
  - Beats: 16'hABCD (out_hi=0, out_last=0), then 16'h1234 (out_hi=1, out_last=1). busy falls the cycle after.
- Words 32'h0001_0002, 32'h0003_0004 offered back-to-back, out_ready=1:
  - out_16 sequence 0002,0001,0004,0003 on four consecutive edges. in_ready=1 on the edge the 0001 beat departs.
- in_32=32'hDEAD_BEEF, out_ready low for 3 cycles in LO, then in HI:
  - out_16 holds BEEF, then DEAD, stable while stalled. in_ready=0 throughout the stall.
- rst pulsed while in HI holding 32'hCAFE_F00D:
  - All outputs return to their reset values immediately. No DEAD/CAFE beat appears after release.
- HI_ZERO_SKIP_EN defined, in_32=32'h0000_00FF:
  - Single beat 16'h00FF with out_last=1. Without the macro: 16'h00FF then 16'h0000 with out_last=1.
